// File: rtl/reg_file_if.sv
// Bus bundle between the decoder/RoB side and the architectural register file:
// rename/commit requests, two source lookups and the RoB value-lookup loop.
interface reg_file_if #(
  parameter int ROB_SIZE_WIDTH = 3
);
  logic                      rdy;
  logic                      clear;
  logic [4:0]                issue_rd;
  logic [ROB_SIZE_WIDTH-1:0] issue_rob_id;
  logic [4:0]                commit_rd;
  logic [ROB_SIZE_WIDTH-1:0] commit_rob_id;
  logic [31:0]               commit_value;
  logic [4:0]                rs1;
  logic [4:0]                rs2;
  logic [ROB_SIZE_WIDTH-1:0] get_rob_id1;
  logic [ROB_SIZE_WIDTH-1:0] get_rob_id2;
  logic [31:0]               get_value1;
  logic [31:0]               get_value2;
  logic                      get_ready1;
  logic                      get_ready2;
  logic [31:0]               val1;
  logic [31:0]               val2;
  logic                      dep1;
  logic                      dep2;
  logic [ROB_SIZE_WIDTH-1:0] tag1;
  logic [ROB_SIZE_WIDTH-1:0] tag2;

  modport master (
    output rdy, clear, issue_rd, issue_rob_id, commit_rd, commit_rob_id, commit_value,
    output rs1, rs2, get_value1, get_value2, get_ready1, get_ready2,
    input  get_rob_id1, get_rob_id2, val1, val2, dep1, dep2, tag1, tag2
  );

  modport slave (
    input  rdy, clear, issue_rd, issue_rob_id, commit_rd, commit_rob_id, commit_value,
    input  rs1, rs2, get_value1, get_value2, get_ready1, get_ready2,
    output get_rob_id1, get_rob_id2, val1, val2, dep1, dep2, tag1, tag2
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register busy bit and RoB rename tag.
// Define REG_FILE_COMMIT_BYPASS_EN to forward a same-cycle commit into lookups.
module reg_file #(
  parameter int ROB_SIZE_WIDTH = 3
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;

  typedef struct packed {
    logic [31:0] val;
    logic        dep;
    tag_t        tag;
  } lookup_t;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  tag_t        tag_q  [32];
  tag_t        tag_d  [32];

  logic        byp1;
  logic        byp2;
  lookup_t     lk1;
  lookup_t     lk2;

  // Priority: x0, committed value, commit bypass, RoB-ready value, else pending tag.
  function automatic lookup_t resolve(
    input logic [4:0]  rs,
    input logic        busy,
    input tag_t        tg,
    input logic [31:0] reg_val,
    input logic        bypass,
    input logic [31:0] byp_val,
    input logic        ready,
    input logic [31:0] rob_val
  );
    lookup_t r;
    r = '0;
    if (rs == 5'd0) begin
      r = '0;
    end else if (!busy) begin
      r.val = reg_val;
    end else if (bypass) begin
      r.val = byp_val;
    end else if (ready) begin
      r.val = rob_val;
    end else begin
      r.dep = 1'b1;
      r.tag = tg;
    end
    return r;
  endfunction

`ifdef REG_FILE_COMMIT_BYPASS_EN
  assign byp1 = (bus.commit_rd != 5'd0) && (bus.commit_rd == bus.rs1) &&
                (bus.commit_rob_id == tag_q[bus.rs1]);
  assign byp2 = (bus.commit_rd != 5'd0) && (bus.commit_rd == bus.rs2) &&
                (bus.commit_rob_id == tag_q[bus.rs2]);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    lk1 = resolve(bus.rs1, busy_q[bus.rs1], tag_q[bus.rs1], regs_q[bus.rs1],
                  byp1, bus.commit_value, bus.get_ready1, bus.get_value1);
    lk2 = resolve(bus.rs2, busy_q[bus.rs2], tag_q[bus.rs2], regs_q[bus.rs2],
                  byp2, bus.commit_value, bus.get_ready2, bus.get_value2);
  end

  assign bus.val1        = lk1.val;
  assign bus.dep1        = lk1.dep;
  assign bus.tag1        = lk1.tag;
  assign bus.val2        = lk2.val;
  assign bus.dep2        = lk2.dep;
  assign bus.tag2        = lk2.tag;
  assign bus.get_rob_id1 = tag_q[bus.rs1];
  assign bus.get_rob_id2 = tag_q[bus.rs2];

  // Issue is applied after commit so a same-register rename keeps busy set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (bus.rdy) begin
      if (bus.commit_rd != 5'd0) begin
        regs_d[bus.commit_rd] = bus.commit_value;
        if (busy_q[bus.commit_rd] && (tag_q[bus.commit_rd] == bus.commit_rob_id)) begin
          busy_d[bus.commit_rd] = 1'b0;
        end
      end
      if (bus.clear) begin
        busy_d = '0;
        for (int i = 0; i < 32; i++) begin
          tag_d[i] = '0;
        end
      end else if (bus.issue_rd != 5'd0) begin
        busy_d[bus.issue_rd] = 1'b1;
        tag_d[bus.issue_rd]  = bus.issue_rob_id;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed and randomized bench for reg_file against an array-based model of the
// architectural state and lookup priority rules.
module tb_reg_file;

  localparam int RW = 3;
`ifdef REG_FILE_COMMIT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_if #(.ROB_SIZE_WIDTH(RW)) bus();
  reg_file #(.ROB_SIZE_WIDTH(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_tag  [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = 0;
    end
  endtask

  // Architectural effect of one rising edge, taken from the inputs held across it.
  task automatic model_edge();
    int cr;
    int ir;
    cr = int'(bus.commit_rd);
    ir = int'(bus.issue_rd);
    if (rst) begin
      model_reset();
    end else if (bus.rdy) begin
      if (cr != 0) begin
        m_regs[cr] = bus.commit_value;
        if (m_busy[cr] && m_tag[cr] == int'(bus.commit_rob_id)) m_busy[cr] = 1'b0;
      end
      if (bus.clear) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0;
          m_tag[i]  = 0;
        end
      end else if (ir != 0) begin
        m_busy[ir] = 1'b1;
        m_tag[ir]  = int'(bus.issue_rob_id);
      end
    end
  endtask

  task automatic exp_lookup(input int rs, input logic rdyn, input logic [31:0] gv,
                            output logic [31:0] v, output logic [31:0] d,
                            output logic [31:0] t);
    v = '0;
    d = '0;
    t = '0;
    if (rs == 0) begin
      v = '0;
    end else if (!m_busy[rs]) begin
      v = m_regs[rs];
    end else if (BYPASS && int'(bus.commit_rd) == rs && int'(bus.commit_rob_id) == m_tag[rs]) begin
      v = bus.commit_value;
    end else if (rdyn) begin
      v = gv;
    end else begin
      d = 32'd1;
      t = m_tag[rs];
    end
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] v;
    logic [31:0] d;
    logic [31:0] t;
    #1;
    exp_lookup(int'(bus.rs1), bus.get_ready1, bus.get_value1, v, d, t);
    check("val1", bus.val1, v);
    check("dep1", {31'd0, bus.dep1}, d);
    check("tag1", {29'd0, bus.tag1}, t);
    check("get_rob_id1", {29'd0, bus.get_rob_id1}, m_tag[bus.rs1]);
    exp_lookup(int'(bus.rs2), bus.get_ready2, bus.get_value2, v, d, t);
    check("val2", bus.val2, v);
    check("dep2", {31'd0, bus.dep2}, d);
    check("tag2", {29'd0, bus.tag2}, t);
    check("get_rob_id2", {29'd0, bus.get_rob_id2}, m_tag[bus.rs2]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.rdy           = 1'b1;
    bus.clear         = 1'b0;
    bus.issue_rd      = '0;
    bus.issue_rob_id  = '0;
    bus.commit_rd     = '0;
    bus.commit_rob_id = '0;
    bus.commit_value  = '0;
    bus.rs1           = '0;
    bus.rs2           = '0;
    bus.get_value1    = '0;
    bus.get_value2    = '0;
    bus.get_ready1    = 1'b0;
    bus.get_ready2    = 1'b0;
  endtask

  task automatic query(input int r1, input int r2);
    idle();
    bus.rs1 = r1[4:0];
    bus.rs2 = r2[4:0];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    query(5, 0);
    #2;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    check("rst_val1", bus.val1, 32'd0);
    check("rst_dep1", {31'd0, bus.dep1}, 32'd0);

    // Rename x3 then retire it.
    idle(); bus.issue_rd = 5'd3; bus.issue_rob_id = 3'd2; step();
    query(3, 0);
    check_all();
    check("x3_dep", {31'd0, bus.dep1}, 32'd1);
    check("x3_tag", {29'd0, bus.tag1}, 32'd2);
    check("x3_robid", {29'd0, bus.get_rob_id1}, 32'd2);
    bus.commit_rd = 5'd3; bus.commit_rob_id = 3'd2; bus.commit_value = 32'h1234;
    check_all();
    step();
    query(3, 0);
    check_all();
    check("x3_val", bus.val1, 32'h1234);
    check("x3_dep_clr", {31'd0, bus.dep1}, 32'd0);

    // Double rename of x4; stale commit keeps it busy.
    idle(); bus.issue_rd = 5'd4; bus.issue_rob_id = 3'd1; step();
    idle(); bus.issue_rd = 5'd4; bus.issue_rob_id = 3'd5; step();
    idle(); bus.commit_rd = 5'd4; bus.commit_rob_id = 3'd1; bus.commit_value = 32'd7; step();
    query(4, 4);
    check_all();
    check("x4_busy", {31'd0, bus.dep1}, 32'd1);
    check("x4_tag", {29'd0, bus.tag1}, 32'd5);
    bus.get_ready1 = 1'b1; bus.get_value1 = 32'd9;
    check_all();
    check("x4_robval", bus.val1, 32'd9);

    // Same-cycle commit and issue to x6.
    idle();
    bus.commit_rd = 5'd6; bus.commit_rob_id = 3'd3; bus.commit_value = 32'hAA;
    bus.issue_rd = 5'd6; bus.issue_rob_id = 3'd4;
    step();
    query(6, 0);
    check_all();
    check("x6_tag", {29'd0, bus.tag1}, 32'd4);

    // Flush with a same-cycle issue that must be dropped.
    idle(); bus.issue_rd = 5'd7; bus.issue_rob_id = 3'd1; step();
    idle(); bus.issue_rd = 5'd8; bus.issue_rob_id = 3'd2; step();
    idle(); bus.issue_rd = 5'd9; bus.issue_rob_id = 3'd3; step();
    idle(); bus.clear = 1'b1; bus.issue_rd = 5'd10; bus.issue_rob_id = 3'd6; step();
    query(10, 9); check_all();
    query(6, 4); check_all();
    check("x6_val", bus.val1, 32'hAA);
    check("x4_val", bus.val2, 32'd7);

    // Writes aimed at x0 are ignored.
    idle(); bus.commit_rd = 5'd0; bus.commit_value = 32'hFFFF;
    bus.issue_rd = 5'd0; bus.issue_rob_id = 3'd3; step();
    query(0, 0); check_all();

    // rdy low freezes state.
    idle(); bus.rdy = 1'b0; bus.commit_rd = 5'd12; bus.commit_value = 32'h77;
    bus.issue_rd = 5'd13; bus.issue_rob_id = 3'd2; step();
    query(12, 13); check_all();
    check("frozen_x12", bus.val1, 32'd0);

    // Asynchronous reset mid-cycle.
    idle(); bus.commit_rd = 5'd12; bus.commit_value = 32'h55; step();
    query(12, 6); check_all();
    #2 rst = 1'b1;
    #1;
    check("async_x12", bus.val1, 32'd0);
    check("async_x6", bus.val2, 32'd0);
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 500; n++) begin
      logic [4:0] cr;
      bus.rdy          = ($urandom_range(0, 9) != 0);
      bus.clear        = ($urandom_range(0, 24) == 0);
      bus.issue_rd     = 5'($urandom_range(0, 7));
      bus.issue_rob_id = 3'($urandom_range(0, 7));
      cr               = 5'($urandom_range(0, 7));
      bus.commit_rd    = cr;
      bus.commit_rob_id = ($urandom_range(0, 2) != 0) ? 3'(m_tag[cr]) : 3'($urandom_range(0, 7));
      bus.commit_value = $urandom;
      bus.rs1          = 5'($urandom_range(0, 7));
      bus.rs2          = 5'($urandom_range(0, 7));
      bus.get_ready1   = 1'($urandom_range(0, 1));
      bus.get_ready2   = 1'($urandom_range(0, 1));
      bus.get_value1   = $urandom;
      bus.get_value2   = $urandom;
      check_all();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the Tomasulo core. Holds x0–x31 values plus a per-register busy bit and reorder-buffer tag. Renames destinations on issue and retires values on commit. For the decoder's two source lookups it returns a ready value or the producing RoB id, resolving in-flight producers through the RoB's combinational value-lookup port.

## Interface
- `ROB_SIZE_WIDTH`, default 3: width of a RoB id; the RoB has 2^`ROB_SIZE_WIDTH` entries.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rdy` input 1: global enable; when low, all state is frozen.
- `clear` input 1: RoB mispredict flush.
- `issue_rd` input 5: destination to rename; 0 = no rename this cycle.
- `issue_rob_id` input `ROB_SIZE_WIDTH`: tag assigned to `issue_rd`.
- `commit_rd` input 5: destination being retired; 0 = no commit this cycle.
- `commit_rob_id` input `ROB_SIZE_WIDTH`: tag of the retiring entry.
- `commit_value` input 32: retired result.
- `rs1`, `rs2` input 5 each: decoder source-register queries.
- `get_rob_id1`, `get_rob_id2` output `ROB_SIZE_WIDTH` each: the current tag of rs1/rs2, sent to the RoB.
- `get_value1`, `get_value2` input 32 each: RoB value for `get_rob_id1`/`get_rob_id2`.
- `get_ready1`, `get_ready2` input 1 each: RoB value valid.
- `val1`, `val2` output 32 each: operand value; valid when the corresponding dep output is 0, else 0.
- `dep1`, `dep2` output 1 each: operand still pending.
- `tag1`, `tag2` output `ROB_SIZE_WIDTH` each: producing RoB id when dep is 1, else 0.

## Operation
- State: `regs[32]` (32b), `busy[32]`, `tag[32]`. Register 0 is never written and never busy.
- **Commit** (rdy, `commit_rd`≠0): `regs[commit_rd]` ← `commit_value`.
  - If `busy[commit_rd]` and `tag[commit_rd]`==`commit_rob_id`, `busy` is cleared.
  - A tag mismatch (the register was renamed again) keeps `busy` set.
- **Issue** (rdy, `issue_rd`≠0, !clear): `busy[issue_rd]` ← 1 and `tag[issue_rd]` ← `issue_rob_id`.
- Issue and commit to the same rd in the same cycle:
  - the value write still happens;
  - the issue's busy/tag update wins over the commit's busy clear.
- **clear** (rdy): all `busy` bits ← 0 and all tags ← 0. A same-cycle commit value write is still performed; a same-cycle issue is dropped.
- **Lookup** (combinational, per source n, priority order):
  - rs==0 → val 0, dep 0.
  - !busy[rs] → val `regs[rs]`, dep 0.
  - busy, bypass hit (see Configuration) → val `commit_value`, dep 0.
  - busy, `get_readyN` → val `get_valueN`, dep 0.
  - otherwise → dep 1, tagN = `tag[rs]`, val 0.
- `get_rob_idN` = `tag[rsN]` unconditionally.
- Lookup reflects state before this cycle's edge, so a same-cycle issue never affects its own sources. Example: `add x1,x1,x1` reads the old x1 mapping.

## Timing
- Reset clears every reg, busy bit and tag asynchronously. With rs1=rs2=0, all outputs are 0 during and after reset.
- Commit and issue updates become visible on lookup outputs the cycle after the edge.
- Lookup path latency: 0 cycles, through the RoB `get_value`/`get_ready` combinational loop. The `get_*` inputs must not depend on `val`/`dep`.
- With rdy low, no state changes. Lookup outputs still track the inputs combinationally.
- Tag wrap-around needs no special handling; the RoB guarantees tag uniqueness among live entries.

## Configuration
- `REG_FILE_COMMIT_BYPASS_EN`
  - Defined: a lookup with busy[rs], `commit_rd`==rs (non-zero) and `commit_rob_id`==`tag[rs]` returns `commit_value` with dep 0 in the same cycle.
  - Undefined: that path is absent and resolution relies solely on `get_readyN`/`get_valueN`. This is functionally equivalent while the RoB reports the head entry as ready during commit.

## Test plan
- Reset, then query rs1=5, rs2=0 → val1=0, dep1=0, val2=0, dep2=0; all tags 0.
- Issue rd=3 tag=2, with RoB get_ready1=0; next cycle query rs1=3 → dep1=1, tag1=2, get_rob_id1=2. Then commit rd=3 tag=2 value 0x1234 → next cycle val1=0x1234, dep1=0.
- Rename x4 to tag 1, then to tag 5; commit x4 tag 1 value 7 → x4 stays busy with tag 5, regs[4]=7. Drive get_ready1=1, get_value1=9 while querying x4 → val1=9, dep1=0.
- Same cycle: commit rd=6 tag 3 value 0xAA and issue rd=6 tag 4 → next cycle busy[6]=1, tag 4, regs[6]=0xAA.
- Busy x7..x9, then assert clear together with issue rd=10 → all busy 0; x10 not busy; values unchanged.
- Write attempts to x0 via commit (value 0xFFFF) and via issue → query rs1=0 returns 0, dep1=0. Assert rst mid-sequence → all state zero immediately, without waiting for a clock edge.
